// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter that shares one USART transmitter among NUM_REQ byte requesters.
// Define USART_TX_ARB_TIMEOUT_EN to abort a stuck frame after TIMEOUT_CLKS clocks and flag it on err.
module usart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BIT     = 8,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         err,
    output logic                         tx_request,
    output logic [DATA_BIT-1:0]          tx_data,
    input  logic                         tx_response,
    output logic                         busy
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    state_t                state_reg;
    logic [PTR_W-1:0]      rr_ptr_reg;
    logic [PTR_W-1:0]      winner_reg;
    logic [NUM_REQ-1:0]    grant_reg;
    logic [NUM_REQ-1:0]    done_reg;
    logic                  tx_request_reg;
    logic [DATA_BIT-1:0]   tx_data_reg;
    logic                  busy_reg;
    logic                  resp_q;

    logic [DATA_BIT-1:0]   req_bytes [NUM_REQ];
    logic [PTR_W-1:0]      cand_idx  [NUM_REQ];
    logic [NUM_REQ-1:0]    win_onehot;
    logic [PTR_W-1:0]      win_next;
    logic                  win_found;
    logic [PTR_W-1:0]      rr_ptr_next;
    logic                  resp_edge;

    // cand_idx[k] is the requester k places after rr_ptr, wrapped modulo NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [PTR_W:0] cand_sum;

            assign req_bytes[gi]  = req_data[gi*DATA_BIT +: DATA_BIT];
            assign cand_sum       = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi]   = (cand_sum >= (PTR_W+1)'(NUM_REQ))
                                  ? PTR_W'(cand_sum - (PTR_W+1)'(NUM_REQ))
                                  : PTR_W'(cand_sum);
            assign win_onehot[gi] = (win_next == PTR_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate back to rr_ptr so the nearest set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_next  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_found = 1'b1;
                win_next  = cand_idx[k];
            end
        end
    end

    assign rr_ptr_next = (winner_reg == PTR_W'(NUM_REQ - 1)) ? '0 : winner_reg + PTR_W'(1);
    assign resp_edge   = tx_response & ~resp_q;

`ifdef USART_TX_ARB_TIMEOUT_EN
    logic [15:0] timeout_cnt_reg;
    logic        err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            winner_reg     <= '0;
            grant_reg      <= '0;
            done_reg       <= '0;
            tx_request_reg <= 1'b0;
            tx_data_reg    <= '0;
            busy_reg       <= 1'b0;
            resp_q         <= 1'b0;
`ifdef USART_TX_ARB_TIMEOUT_EN
            timeout_cnt_reg <= '0;
            err_reg         <= 1'b0;
`endif
        end else begin
            resp_q <= tx_response;
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        winner_reg     <= win_next;
                        grant_reg      <= win_onehot;
                        tx_data_reg    <= req_bytes[win_next];
                        tx_request_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tx_request_reg <= 1'b0;
                    state_reg      <= ST_BUSY;
`ifdef USART_TX_ARB_TIMEOUT_EN
                    timeout_cnt_reg <= '0;
`endif
                end
                ST_BUSY: begin
                    // Only a fresh rising edge completes; a response left high from before is ignored.
                    if (resp_edge) begin
                        done_reg  <= grant_reg;
                        state_reg <= ST_RELEASE;
                    end
`ifdef USART_TX_ARB_TIMEOUT_EN
                    else if (timeout_cnt_reg == 16'(TIMEOUT_CLKS - 1)) begin
                        done_reg  <= grant_reg;
                        err_reg   <= 1'b1;
                        state_reg <= ST_RELEASE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
`endif
                end
                ST_RELEASE: begin
                    done_reg   <= '0;
                    grant_reg  <= '0;
                    busy_reg   <= 1'b0;
                    rr_ptr_reg <= rr_ptr_next;
                    state_reg  <= ST_IDLE;
`ifdef USART_TX_ARB_TIMEOUT_EN
                    err_reg    <= 1'b0;
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign grant      = grant_reg;
    assign done       = done_reg;
    assign tx_request = tx_request_reg;
    assign tx_data    = tx_data_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Scoreboard bench for usart_tx_arbiter: directed scenarios plus random arrivals against a round-robin model.
// Timeout scenario follows USART_TX_ARB_TIMEOUT_EN.
module tb_usart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            err;
    logic            tx_request;
    logic [DB-1:0]   tx_data;
    logic            tx_response = 1'b0;
    logic            busy;

    usart_tx_arbiter #(.NUM_REQ(N), .DATA_BIT(DB), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .tx_request(tx_request),
        .tx_data(tx_data), .tx_response(tx_response), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int        rem [N];
    logic [7:0] cur_data [N];
    int        rise_cyc [N];
    bit        fixed_data = 1'b1;
    bit        auto_tx = 1'b1;
    bit        man_resp = 1'b0;
    bit        lat_check = 1'b0;
    bit        exp_err_flag = 1'b0;
    int        tx_cnt = 0;

    int        exp_idx_q [$];
    logic [7:0] exp_data_q [$];
    int        infl_idx_q [$];
    bit        infl_err_q [$];
    int        exp_done_cyc_q [$];

    int        model_ptr = 0;
    int        done_total = 0;
    int        grant_total = 0;
    int        last_issue_cyc = 0;
    int        last_done_cyc = 0;
    logic [N-1:0]    req_hist = '0;
    logic [N*DB-1:0] data_hist = '0;
    logic [N-1:0]    done_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Requesters: hold req with stable data until done, then move to the next byte.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (done[i] && rem[i] > 0) begin
                rem[i]--;
                if (!fixed_data) cur_data[i] = 8'($urandom);
            end
            if (rem[i] > 0 && !req[i]) rise_cyc[i] = cyc;
            req[i] = (rem[i] > 0);
            req_data[i*DB +: DB] = cur_data[i];
        end
    end

    // Transmitter model: auto mode completes after 1..6 BUSY cycles, manual mode follows man_resp.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            tx_cnt = 0;
            tx_response = auto_tx ? 1'b0 : man_resp;
        end else if (auto_tx) begin
            if (tx_request) begin
                tx_response = 1'b0;
                tx_cnt = $urandom_range(1, 6);
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_response = 1'b1;
                    exp_done_cyc_q.push_back(cyc + 1);
                end
            end
        end else begin
            if (man_resp && !tx_response && busy && !tx_request && done == '0)
                exp_done_cyc_q.push_back(cyc + 1);
            tx_response = man_resp;
        end
    end

    // Monitor: predicts each grant from the round-robin rule and checks completions.
    int win;
    int idx;
    always @(negedge clk) begin
        if (reset) begin
            infl_idx_q.delete();
            infl_err_q.delete();
            exp_done_cyc_q.delete();
            model_ptr = 0;
            done_prev = '0;
        end else begin
            if (!busy) begin
                chk("idle_grant", grant, 0);
                chk("idle_tx_request", tx_request, 0);
                chk("idle_done", done, 0);
                chk("idle_err", err, 0);
            end
            if (tx_request) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (model_ptr + k) % N;
                    if (win < 0 && req_hist[idx]) win = idx;
                end
                grant_total++;
                last_issue_cyc = cyc;
                if (win < 0) begin
                    chk("grant_without_request", grant, 0);
                end else begin
                    chk("grant_onehot", grant, 1 << win);
                    chk("tx_data", tx_data, data_hist[win*DB +: DB]);
                    chk("busy_on_issue", busy, 1);
                    if (exp_idx_q.size() > 0) begin
                        chk("directed_order", win, exp_idx_q.pop_front());
                        chk("directed_data", tx_data, exp_data_q.pop_front());
                    end
                    if (lat_check) chk("issue_latency", cyc - rise_cyc[win], 1);
                    infl_idx_q.push_back(win);
                    infl_err_q.push_back(exp_err_flag);
                    model_ptr = (win + 1) % N;
                end
            end
            if (done != '0) begin
                done_total++;
                last_done_cyc = cyc;
                chk("done_single_cycle", done_prev, 0);
                if (infl_idx_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    idx = infl_idx_q.pop_front();
                    chk("done_onehot", done, 1 << idx);
                    chk("done_err", err, infl_err_q.pop_front());
                    $display("xfer req=%0d data=%02h err=%0b cyc=%0d", idx, tx_data, err, cyc);
                end
                if (exp_done_cyc_q.size() > 0) chk("done_latency", cyc, exp_done_cyc_q.pop_front());
            end else if (err) begin
                chk("err_without_done", err, 0);
            end
            done_prev = done;
            req_hist  = req;
            data_hist = req_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit any_rem();
        for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((any_rem() || busy || infl_idx_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        exp_idx_q.delete();
        exp_data_q.delete();
        exp_err_flag = 1'b0;
        man_resp = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_idx_q.push_back(i);
        exp_data_q.push_back(d);
    endtask

    int d0;
    int g0;
    int n;

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            cur_data[i] = '0;
            rise_cyc[i] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_request", tx_request, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);

        // Single requester with issue latency checked
        d0 = done_total;
        lat_check = 1'b1;
        cur_data[1] = 8'h0A;
        push_exp(1, 8'h0A);
        rem[1] = 1;
        wait_idle("single_idle", 100);
        lat_check = 1'b0;
        chk("single_done_count", done_total - d0, 1);

        // All requesting from reset: 0,1,2,3,0
        do_reset();
        g0 = grant_total;
        for (int i = 0; i < N; i++) cur_data[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < N; i++) push_exp(i, 8'hA0 + 8'(i));
        push_exp(0, 8'hA0);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        wait_idle("simul_idle", 200);
        chk("simul_grants", grant_total - g0, 5);
        chk("simul_queue_drained", exp_idx_q.size(), 0);

        // Fairness: requester 2 arriving mid-stream is served before 0 again
        do_reset();
        g0 = grant_total;
        cur_data[0] = 8'hC0;
        cur_data[2] = 8'hC2;
        push_exp(0, 8'hC0); push_exp(2, 8'hC2); push_exp(0, 8'hC0); push_exp(0, 8'hC0);
        rem[0] = 3;
        n = 0;
        while (grant_total == g0 && n < 50) begin tick(); n++; end
        chk("fair_first_grant", grant_total - g0, 1);
        rem[2] = 1;
        wait_idle("fair_idle", 200);
        chk("fair_queue_drained", exp_idx_q.size(), 0);

        // Stale tx_response: only a fresh rising edge completes
        do_reset();
        auto_tx = 1'b0;
        man_resp = 1'b1;
        repeat (3) tick();
        d0 = done_total;
        cur_data[3] = 8'h5A;
        push_exp(3, 8'h5A);
        rem[3] = 1;
        repeat (12) tick();
        chk("stale_no_done", done_total - d0, 0);
        chk("stale_busy", busy, 1);
        man_resp = 1'b0;
        tick();
        tick();
        man_resp = 1'b1;
        n = 0;
        while (done_total == d0 && n < 10) begin tick(); n++; end
        chk("stale_edge_done", done_total - d0, 1);
        repeat (10) tick();
        chk("stale_one_done", done_total - d0, 1);
        chk("stale_idle", busy, 0);
        man_resp = 1'b0;
        auto_tx = 1'b1;

        // Reset mid-BUSY aborts silently and restarts the pointer at 0
        do_reset();
        auto_tx = 1'b0;
        cur_data[2] = 8'h77;
        rem[2] = 1;
        n = 0;
        while (!(busy && !tx_request) && n < 20) begin tick(); n++; end
        repeat (3) tick();
        chk("rb_in_busy", busy, 1);
        d0 = done_total;
        for (int i = 0; i < N; i++) rem[i] = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rb_grant", grant, 0);
        chk("rb_busy", busy, 0);
        chk("rb_tx_request", tx_request, 0);
        chk("rb_done", done, 0);
        chk("rb_err", err, 0);
        repeat (5) tick();
        chk("rb_no_done", done_total - d0, 0);
        auto_tx = 1'b1;
        cur_data[1] = 8'h11;
        cur_data[3] = 8'h33;
        push_exp(1, 8'h11);
        push_exp(3, 8'h33);
        rem[1] = 1;
        rem[3] = 1;
        wait_idle("rb_after_idle", 100);

        // Transmitter never responds
        do_reset();
        auto_tx = 1'b0;
        man_resp = 1'b0;
        d0 = done_total;
`ifdef USART_TX_ARB_TIMEOUT_EN
        exp_err_flag = 1'b1;
        rem[2] = 1;
        n = 0;
        while (done_total == d0 && n < 60) begin tick(); n++; end
        chk("to_done", done_total - d0, 1);
        chk("to_cycle", last_done_cyc - last_issue_cyc, TO + 1);
        wait_idle("to_idle", 20);
        exp_err_flag = 1'b0;
`else
        rem[2] = 1;
        repeat (60) tick();
        chk("to_still_busy", busy, 1);
        chk("to_no_err", err, 0);
        chk("to_no_done", done_total - d0, 0);
`endif
        auto_tx = 1'b1;
        do_reset();

        // Random arrivals against the round-robin model
        fixed_data = 1'b0;
        d0 = done_total;
        g0 = grant_total;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
                    cur_data[i] = 8'($urandom);
                    rem[i] = $urandom_range(1, 3);
                end
            end
            tick();
        end
        wait_idle("rand_idle", 500);
        chk("rand_done_eq_grant", done_total - d0, grant_total - g0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/usart_tx_arbiter.md
Name: usart_tx_arbiter

Overview:
- Shares one USART transmitter (10-bit frames, level-type tx_request/tx_response handshake) among NUM_REQ independent requesters.
- Round-robin arbitration at byte granularity. Sequences each byte into the transmitter and reports per-requester completion.
- Sits between client logic (command/status producers) and the transmitter instance inside the USART controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BIT, 8, byte width per requester; must match the transmitter.
- TIMEOUT_CLKS, 2048, max clocks to wait for transmitter completion (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester level request. Held high, with data stable, until the matching done pulse.
- req_data  input  NUM_REQ*DATA_BIT  flat data bus; requester i occupies bits [i*DATA_BIT +: DATA_BIT].
- grant  output  NUM_REQ  one-hot, high while requester's byte is in flight (ISSUE through RELEASE).
- done  output  NUM_REQ  one-hot, single-cycle completion pulse.
- err  output  1  single-cycle pulse coincident with done when the transfer was aborted by timeout; constant 0 without the optional feature.
- tx_request  output  1  to transmitter; one-cycle pulse starting a frame.
- tx_data  output  DATA_BIT  to transmitter; registered copy of the granted byte, stable from ISSUE until the next grant.
- tx_response  input  1  from transmitter; level, rises at end of frame, cleared by the transmitter on the next tx_request.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0, done=0, err=0, tx_request=0, tx_data=0, busy=0, resp_q=0. Reset mid-transfer aborts silently: no done, no err. The transmitter is reset by the same signal.
- All outputs are registered.
- resp_q is a register holding the previous tx_response. Completion is the rising edge only: tx_response=1 and resp_q=0. A stale high tx_response never completes a transfer.

FSM:
- IDLE: if any req bit is set, pick the winner. Search from rr_ptr upward, wrapping modulo NUM_REQ; the first set bit wins. Latch its req_data into tx_data, set grant one-hot, go to ISSUE.
- ISSUE (1 cycle): tx_request=1. Go to BUSY.
- BUSY: tx_request=0. Wait for the tx_response rising edge, then go to RELEASE.
- RELEASE (1 cycle): done[winner]=1. Set rr_ptr to (winner+1) mod NUM_REQ. Clear grant, go to IDLE.

Latency:
- req visible in IDLE at cycle N: grant and tx_data valid at N+1, tx_request high at N+1.
- Edge seen at cycle M: done at M+1.
- Minimum 2 idle-side cycles between consecutive tx_request pulses (RELEASE, IDLE).

Request rules and boundary conditions:
- req bits are sampled only in IDLE. Changes to req or req_data while granted are ignored; tx_data is already latched.
- A requester still asserting req in the IDLE cycle after its done is treated as a new request. Round-robin still gives every other pending requester priority first.
- Deassertion of req while granted does not abort the transfer; done still pulses.
- All requests simultaneously from reset: service order 0,1,2,3,0,...
- No request: remain in IDLE, all outputs 0.

Optional Feature:
- Macro: USART_TX_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears on ISSUE and increments each BUSY cycle.
  - If it reaches TIMEOUT_CLKS before a tx_response edge, go to RELEASE with done[winner]=1 and err=1.
  - rr_ptr advances as normal.
- Disabled:
  - No counter logic; BUSY waits indefinitely.
  - err tied to 0.

Test Plan:
- Single requester: req=4'b0010, data1=8'h0A. Expected: grant=4'b0010 and tx_request pulse one cycle after req; tx_data=8'h0A. After model raises tx_response, done=4'b0010 for exactly one cycle; err=0.
- Simultaneous: req=4'b1111 held, data i = 8'hA0+i. Expected: tx_data sequence A0,A1,A2,A3,A0; exactly one grant bit per transfer; done order 0,1,2,3.
- Fairness: req0 held continuously, req2 asserted once. Expected: after the current req0 byte, the next grant goes to requester 2 before req0 is served again.
- Stale response: tx_response tied high before the request. Expected: no done until the model drops and re-raises tx_response; one done per rising edge.
- Reset in BUSY: reset for 1 cycle mid-frame. Expected: next cycle grant=0, busy=0, tx_request=0, no done or err pulse; rr_ptr=0.
- Timeout (macro defined, TIMEOUT_CLKS=16): tx_response held 0. Expected: done and err pulse together at BUSY cycle 16; arbiter returns to IDLE. With macro undefined: busy stays 1 and err stays 0.
